// File: rtl/hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO control unit: op codes, calculator
// select codes and FSM state type.
package hilo_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } op_e;

    localparam logic [1:0] SEL_MUL  = 2'd0;
    localparam logic [1:0] SEL_MULU = 2'd1;
    localparam logic [1:0] SEL_DIV  = 2'd2;
    localparam logic [1:0] SEL_DIVU = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    function automatic logic is_muldiv(logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div(logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic [1:0] sel_of(logic [2:0] op);
        logic [1:0] s;
        s = SEL_MUL;
        unique case (1'b1)
            (op == OP_MULTU): s = SEL_MULU;
            (op == OP_DIV):   s = SEL_DIV;
            (op == OP_DIVU):  s = SEL_DIVU;
            default:          s = SEL_MUL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hilo_ctrl_regs.sv
// HI/LO register pair; calculator result port beats MTHI/MTLO port.
// HILO_BYPASS_EN forwards the value being written this cycle.
module hilo_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        calc_we_i,
    input  logic [31:0] calc_hi_i,
    input  logic [31:0] calc_lo_i,
    input  logic        mt_hi_we_i,
    input  logic        mt_lo_we_i,
    input  logic [31:0] mt_data_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (calc_we_i) begin
            hi_d = calc_hi_i;
            lo_d = calc_lo_i;
        end else begin
            if (mt_hi_we_i) hi_d = mt_data_i;
            if (mt_lo_we_i) lo_d = mt_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi_o = hi_d;
    assign lo_o = lo_d;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO control: issues mult/div to the calculator, stalls until result.
// Optional HILO_BYPASS_EN forwards HI/LO writes combinationally.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        calc_ena,
    output logic [31:0] calc_a,
    output logic [31:0] calc_b,
    output logic [1:0]  calc_sel,
    input  logic [31:0] calc_lo,
    input  logic [31:0] calc_hi,
    input  logic        calc_finish,
    output logic        stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic        calc_ena_q, err_q;
    logic [31:0] a_q, b_q;
    logic [1:0]  sel_q;

    logic idle, div0, accept, calc_we;
    logic mt_hi_we, mt_lo_we, mf_busy;

    assign idle   = (state_q == S_IDLE);
    assign div0   = is_div(op_code) && (rt_data == '0);
    assign accept = idle && op_valid && is_muldiv(op_code) && !div0;

    // A result arriving in the abort cycle is dropped.
    assign calc_we  = (state_q == S_WAIT) && calc_finish && !err_q;
    assign mt_hi_we = idle && op_valid && (op_code == OP_MTHI);
    assign mt_lo_we = idle && op_valid && (op_code == OP_MTLO);
    assign mf_busy  = op_valid && !idle &&
                      (op_code == OP_MFHI || op_code == OP_MFLO);

    assign stall = !rst && (!idle || accept || mf_busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            calc_ena_q <= 1'b0;
            err_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
        end else begin
            calc_ena_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q        <= rs_data;
                        b_q        <= rt_data;
                        sel_q      <= sel_of(op_code);
                        calc_ena_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (err_q || calc_finish) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign calc_ena = calc_ena_q;
    assign err      = err_q;
    assign calc_a   = a_q;
    assign calc_b   = b_q;
    assign calc_sel = sel_q;

    hilo_regs u_regs (
        .clk        (clk),
        .rst        (rst),
        .calc_we_i  (calc_we),
        .calc_hi_i  (calc_hi),
        .calc_lo_i  (calc_lo),
        .mt_hi_we_i (mt_hi_we),
        .mt_lo_we_i (mt_lo_we),
        .mt_data_i  (rs_data),
        .hi_o       (hi_out),
        .lo_o       (lo_out)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed table, reset/timeout sequences and
// random ops against a transaction-level HI/LO model.
module tb_hilo_ctrl;
    import hilo_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_data, rt_data;
    logic [31:0] calc_lo, calc_hi;
    logic        calc_finish;

    logic        ena0, err0, stall0;
    logic [31:0] a0, b0, hi0, lo0;
    logic [1:0]  sel0;
    logic        ena8, err8, stall8;
    logic [31:0] a8, b8, hi8, lo8;
    logic [1:0]  sel8_o;

    logic        use8;
    logic        m_ena, m_err, m_stall;
    logic [31:0] m_a, m_b, m_hi, m_lo;
    logic [1:0]  m_sel;

    int nchk = 0;
    int npass = 0;
    int nfail = 0;
    int to_cur;
    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    hilo_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .rs_data(rs_data), .rt_data(rt_data), .calc_ena(ena0),
        .calc_a(a0), .calc_b(b0), .calc_sel(sel0), .calc_lo(calc_lo),
        .calc_hi(calc_hi), .calc_finish(calc_finish), .stall(stall0),
        .hi_out(hi0), .lo_out(lo0), .err(err0)
    );

    hilo_ctrl #(.TIMEOUT(8)) dut8 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .rs_data(rs_data), .rt_data(rt_data), .calc_ena(ena8),
        .calc_a(a8), .calc_b(b8), .calc_sel(sel8_o), .calc_lo(calc_lo),
        .calc_hi(calc_hi), .calc_finish(calc_finish), .stall(stall8),
        .hi_out(hi8), .lo_out(lo8), .err(err8)
    );

    assign m_ena   = use8 ? ena8   : ena0;
    assign m_err   = use8 ? err8   : err0;
    assign m_stall = use8 ? stall8 : stall0;
    assign m_a     = use8 ? a8     : a0;
    assign m_b     = use8 ? b8     : b0;
    assign m_sel   = use8 ? sel8_o : sel0;
    assign m_hi    = use8 ? hi8    : hi0;
    assign m_lo    = use8 ? lo8    : lo0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_sel(logic [2:0] op);
        case (op)
            3'd0:    return SEL_MUL;
            3'd1:    return SEL_MULU;
            3'd2:    return SEL_DIV;
            default: return SEL_DIVU;
        endcase
    endfunction

    // Starts and ends just after a posedge. lat = cycles from calc_ena to
    // calc_finish, 0 = never. stl = expected stall cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int lat,
                          input logic [31:0] fhi, input logic [31:0] flo,
                          input int stl, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int ncyc;
        bit terr;
        ncyc = (stl > 0) ? stl : 1;
        terr = (lat == 0) && (stl > 0);
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                op_valid = 1'b1; op_code = op;
                rs_data = rs; rt_data = rt;
            end else begin
                op_valid = 1'($urandom_range(0, 1));
                op_code = 3'($urandom_range(0, 7));
                rs_data = $urandom; rt_data = $urandom;
            end
            if (lat != 0 && c == 1 + lat) begin
                calc_finish = 1'b1; calc_hi = fhi; calc_lo = flo;
            end else begin
                calc_finish = (c == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                calc_hi = $urandom; calc_lo = $urandom;
            end
            @(negedge clk);
            chk("stall", 32'(m_stall), 32'(c < stl));
            chk("calc_ena", 32'(m_ena), 32'(stl > 0 && c == 1));
            chk("err", 32'(m_err), 32'(terr && c == stl - 1));
            if (c >= 1) begin
                chk("calc_a", m_a, rs);
                chk("calc_b", m_b, rt);
                chk("calc_sel", 32'(m_sel), 32'(exp_sel(op)));
            end
            if (c == 0 && (op == 3'd6 || op == 3'd7)) begin
                chk("mf_hi", m_hi, ehi);
                chk("mf_lo", m_lo, elo);
            end
            @(posedge clk); #1;
        end
        op_valid = 1'b0; calc_finish = 1'b0;
        @(negedge clk);
        chk("post_stall", 32'(m_stall), 32'd0);
        chk("post_err", 32'(m_err), 32'd0);
        chk("post_ena", 32'(m_ena), 32'd0);
        chk("hi_out", m_hi, ehi);
        chk("lo_out", m_lo, elo);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt;
        int          lat;
        logic [31:0] fhi, flo;
        int          stl;
        logic [31:0] ehi, elo;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{3'd0, 32'hFFFFFFFF, 32'd2, 3, 32'hFFFFFFFF, 32'hFFFFFFFE,
                   5, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[1] = '{3'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14, 35, 32'd2, 32'd14};
        tbl[2] = '{3'd4, 32'd5, 32'd0, 0, 32'd0, 32'd0, 0, 32'd5, 32'd14};
        tbl[3] = '{3'd5, 32'd9, 32'd0, 0, 32'd0, 32'd0, 0, 32'd5, 32'd9};
        tbl[4] = '{3'd2, 32'd77, 32'd0, 0, 32'd0, 32'd0, 0, 32'd5, 32'd9};
        tbl[5] = '{3'd5, 32'h1234, 32'd0, 0, 32'd0, 32'd0, 0, 32'd5, 32'h1234};
        tbl[6] = '{3'd7, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd5, 32'h1234};
        tbl[7] = '{3'd1, 32'h10000, 32'h10000, 1, 32'd1, 32'd0,
                   3, 32'd1, 32'd0};
        tbl[8] = '{3'd3, 32'd50, 32'd0, 0, 32'd0, 32'd0, 0, 32'd1, 32'd0};
        tbl[9] = '{3'd6, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd1, 32'd0};

        use8 = 1'b0;
        rst = 1'b1; op_valid = 1'b0; op_code = '0;
        rs_data = '0; rt_data = '0; calc_hi = '0; calc_lo = '0;
        calc_finish = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", 32'(m_stall), 32'd0);
        chk("rst_ena", 32'(m_ena), 32'd0);
        chk("rst_hi", m_hi, 32'd0);
        chk("rst_lo", m_lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].lat, tbl[i].fhi,
                   tbl[i].flo, tbl[i].stl, tbl[i].ehi, tbl[i].elo);

        // Reset while waiting on the calculator, then a stale finish.
        op_valid = 1'b1; op_code = 3'd0; rs_data = 32'd3; rt_data = 32'd4;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; op_valid = 1'b1;
        @(negedge clk);
        chk("wrst_stall", 32'(m_stall), 32'd0);
        chk("wrst_ena", 32'(m_ena), 32'd0);
        chk("wrst_err", 32'(m_err), 32'd0);
        chk("wrst_a", m_a, 32'd0);
        chk("wrst_b", m_b, 32'd0);
        chk("wrst_sel", 32'(m_sel), 32'd0);
        chk("wrst_hi", m_hi, 32'd0);
        chk("wrst_lo", m_lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;
        calc_finish = 1'b1; calc_hi = 32'hDEAD; calc_lo = 32'hBEEF;
        @(negedge clk);
        chk("stale_stall", 32'(m_stall), 32'd0);
        @(posedge clk); #1;
        calc_finish = 1'b0;
        @(negedge clk);
        chk("stale_hi", m_hi, 32'd0);
        chk("stale_lo", m_lo, 32'd0);
        chk("stale_ena", 32'(m_ena), 32'd0);
        @(posedge clk); #1;

        // Timeout on the TIMEOUT=8 instance.
        use8 = 1'b1; to_cur = 8;
        run_op(3'd4, 32'hAAAA, 32'd0, 0, 32'd0, 32'd0, 0, 32'hAAAA, 32'd0);
        run_op(3'd5, 32'h5555, 32'd0, 0, 32'd0, 32'd0, 0, 32'hAAAA, 32'h5555);
        run_op(3'd0, 32'd6, 32'd7, 0, 32'd0, 32'd0, to_cur + 3,
               32'hAAAA, 32'h5555);
        hi_m = 32'hAAAA; lo_m = 32'h5555;

        for (int k = 0; k < 150; k++) begin
            logic [2:0]  op;
            logic [31:0] rs, rt, fhi, flo;
            logic [63:0] p;
            int lat, stl;
            op = 3'($urandom_range(0, 7));
            rs = $urandom; rt = $urandom;
            if (op[2:1] == 2'b01 && $urandom_range(0, 3) == 0) rt = '0;
            if (op == 3'd2 && rs == 32'h80000000 && rt == 32'hFFFFFFFF)
                rt = 32'd1;
            lat = $urandom_range(0, to_cur);
            fhi = '0; flo = '0; stl = 0;
            case (op)
                3'd0: begin
                    p = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
                    fhi = p[63:32]; flo = p[31:0];
                end
                3'd1: begin
                    p = {32'd0, rs} * {32'd0, rt};
                    fhi = p[63:32]; flo = p[31:0];
                end
                3'd2: if (rt != 0) begin
                    flo = $signed(rs) / $signed(rt);
                    fhi = $signed(rs) % $signed(rt);
                end
                3'd3: if (rt != 0) begin
                    flo = rs / rt; fhi = rs % rt;
                end
                3'd4: hi_m = rs;
                3'd5: lo_m = rs;
                default: ;
            endcase
            if (op[2] == 1'b0 && !(op[1] && rt == 0)) begin
                if (lat == 0) stl = to_cur + 3;
                else begin
                    stl = lat + 2; hi_m = fhi; lo_m = flo;
                end
            end
            run_op(op, rs, rt, lat, fhi, flo, stl, hi_m, lo_m);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 63, max cycles spent in WAIT before abort.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op_valid  input  1  decode stage presents a HI/LO-class instruction this cycle.
REQ-005 op_code  input  3  MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO (encodings in shared package).
REQ-006 rs_data, rt_data  input  32 each  operands; MTHI/MTLO use rs_data.
REQ-007 calc_ena  output  1  one-cycle start pulse to the multiply/divide calculator.
REQ-008 calc_a, calc_b  output  32 each  operands latched at accept, held stable until completion.
REQ-009 calc_sel  output  2  calculator operation select (MUL/MULU/DIV/DIVU codes), held stable until completion.
REQ-010 calc_lo, calc_hi  input  32 each  calculator results; calc_finish  input  1  result-valid pulse.
REQ-011 stall  output  1  freezes upstream pipeline; hi_out, lo_out  output  32 each  architectural HI/LO; err  output  1  timeout pulse.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT; encoding is implementation choice.
REQ-013 IDLE + op_valid + mult/div op: latch rs_data/rt_data/op -> ISSUE on next edge.
REQ-014 ISSUE: calc_ena=1 for exactly one cycle -> WAIT.
REQ-015 WAIT + calc_finish: HI<=calc_hi, LO<=calc_lo on that edge -> IDLE.
REQ-016 WAIT cycle counter reaching TIMEOUT without calc_finish: err=1 one cycle, HI/LO unchanged -> IDLE.
REQ-017 DIV/DIVU with rt_data==0: no calc_ena, HI/LO unchanged, stay IDLE, stall=0 (zero-latency no-op).
REQ-018 stall = (state!=IDLE) OR (op_valid AND mult/div op AND state==IDLE AND not divide-by-zero) OR (op_valid AND MFHI/MFLO AND state!=IDLE).
REQ-019 Stall deasserts the cycle after the HI/LO write edge; total stall = N+2 cycles, N = cycles from calc_ena to calc_finish.
REQ-020 MTHI/MTLO in IDLE: write HI (or LO) from rs_data on next edge, no stall.
REQ-021 MFHI/MFLO need no action in IDLE; consumer reads hi_out/lo_out.
REQ-022 op_valid while state!=IDLE ignored; upstream re-presents under stall.
REQ-023 calc_finish in IDLE or ISSUE ignored.
REQ-024 calc_a/calc_b/calc_sel do not change between accept and return to IDLE.

Reset
REQ-025 rst asserted at any time, incl. mid-operation: state=IDLE, HI=LO=0, counter=0, calc_ena=0, stall=0, err=0, calc_a=calc_b=0, calc_sel=0.
REQ-026 Result of an operation in flight at reset is discarded; calculator receives the same rst.

Configuration
REQ-027 HILO_BYPASS_EN defined: hi_out/lo_out combinationally forward the value being written this cycle (finish or MTHI/MTLO).
REQ-028 HILO_BYPASS_EN undefined: hi_out/lo_out driven from registers only; new value visible the cycle after the write edge.

Structure
REQ-029 Shared package holds op_code encodings, calc_sel codes (identical to calculator MUL/MULU/DIV/DIVU codes) and FSM state type.
REQ-030 One sub-module hilo_regs: HI/LO register pair with two write ports (calc result, MTHI/MTLO), calc result wins if simultaneous.

Verification
REQ-031 MULT rs=0xFFFFFFFF rt=2, finish 3 cycles after calc_ena, calc_hi=0xFFFFFFFF calc_lo=0xFFFFFFFE -> stall 5 cycles, HI/LO match, calc_sel=MUL.
REQ-032 DIVU rs=100 rt=7, finish after 33 cycles -> calc_ena single pulse, LO=14 HI=2, stall 35 cycles.
REQ-033 DIV rt=0 with HI=5 LO=9 -> no calc_ena, stall=0, HI=5 LO=9.
REQ-034 MTLO rs=0x1234 then MFLO next cycle -> lo_out=0x1234 (with HILO_BYPASS_EN: visible same cycle as write).
REQ-035 rst asserted in WAIT, then calc_finish pulse -> state IDLE, HI=LO=0, stall=0, finish ignored.
REQ-036 TIMEOUT=8, calc_finish never arrives -> err pulse 8 cycles into WAIT, stall drops next cycle, HI/LO unchanged.
